// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for the 8-bit PWM core: steps duty toward a target once per
// PWM period, dwells at the target for a programmed number of periods, then pulses done.
module pwm_ramp_ctrl #(
    parameter int DW      = 8,
    parameter int RES_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ena,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [DW-1:0]      i_cfg_target,
    input  logic [DW-1:0]      i_cfg_step,
    input  logic [RES_W-1:0]   i_cfg_res,
    input  logic [DWELL_W-1:0] i_cfg_dwell,
    input  logic               i_abort,
    output logic [DW-1:0]      o_duty_out,
    output logic [RES_W-1:0]   o_res_out,
    output logic               o_period_tick,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DW:0]        r_pcnt;
    logic [DW:0]        w_pcnt_nxt;
    logic [DW:0]        w_plim;
    logic [DW-1:0]      r_duty;
    logic [DW-1:0]      w_duty_nxt;
    logic [DW-1:0]      r_target;
    logic [DW-1:0]      w_target_nxt;
    logic [DW-1:0]      r_step;
    logic [DW-1:0]      w_step_nxt;
    logic [DW-1:0]      w_duty_step;
    logic [RES_W-1:0]   r_res;
    logic [RES_W-1:0]   w_res_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_cnt_nxt;
    logic               w_tick;
    logic               w_accept;

    // One step toward the target in DW+1-bit arithmetic; clamps onto the target instead of overshooting.
    function automatic logic [DW-1:0] f_step_toward(input logic [DW-1:0] cur,
                                                    input logic [DW-1:0] tgt,
                                                    input logic [DW-1:0] stp);
        logic [DW:0] diff;
        logic [DW:0] nxt;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            nxt  = (diff <= {1'b0, stp}) ? {1'b0, tgt} : ({1'b0, cur} + {1'b0, stp});
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            nxt  = (diff <= {1'b0, stp}) ? {1'b0, tgt} : ({1'b0, cur} - {1'b0, stp});
        end
        return nxt[DW-1:0];
    endfunction

    assign w_plim        = {{DW{1'b0}}, 1'b1} << r_res;
    assign w_tick        = i_ena && (r_pcnt == w_plim);
    assign w_accept      = i_ena && (r_state == ST_IDLE) && i_cfg_valid;
    assign w_duty_step   = f_step_toward(r_duty, r_target, r_step);

    assign o_cfg_ready   = i_ena && (r_state == ST_IDLE);
    assign o_period_tick = w_tick;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = i_ena && (r_state == ST_DONE);
    assign o_duty_out    = r_duty;
    assign o_res_out     = r_res;

    // Next-state and next-datapath logic; ena low leaves every register unchanged.
    always_comb begin
        w_state_nxt     = r_state;
        w_pcnt_nxt      = r_pcnt;
        w_duty_nxt      = r_duty;
        w_target_nxt    = r_target;
        w_step_nxt      = r_step;
        w_res_nxt       = r_res;
        w_dwell_nxt     = r_dwell;
        w_dwell_cnt_nxt = r_dwell_cnt;
        if (!i_ena) begin
            w_state_nxt = r_state;
        end else begin
            // Period counter restarts on acceptance so the first update is one full period later.
            if (w_accept) begin
                w_pcnt_nxt = {(DW + 1){1'b0}};
            end else if (r_pcnt == w_plim) begin
                w_pcnt_nxt = {(DW + 1){1'b0}};
            end else begin
                w_pcnt_nxt = r_pcnt + {{DW{1'b0}}, 1'b1};
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_valid) begin
                        w_target_nxt = i_cfg_target;
                        w_step_nxt   = (i_cfg_step == {DW{1'b0}}) ? {{(DW - 1){1'b0}}, 1'b1} : i_cfg_step;
                        w_dwell_nxt  = i_cfg_dwell;
                        w_res_nxt    = i_cfg_res;
                        w_state_nxt  = ST_RAMP;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_RAMP: begin
                    if (i_abort) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_tick) begin
                        w_duty_nxt = w_duty_step;
                        if (w_duty_step == r_target) begin
                            w_state_nxt     = ST_HOLD;
                            w_dwell_cnt_nxt = r_dwell;
                        end else begin
                            w_state_nxt     = ST_RAMP;
                        end
                    end else begin
                        w_state_nxt = ST_RAMP;
                    end
                end
                ST_HOLD: begin
                    if (i_abort) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_dwell_cnt == {DWELL_W{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_tick) begin
                        w_dwell_cnt_nxt = r_dwell_cnt - {{(DWELL_W - 1){1'b0}}, 1'b1};
                        if (r_dwell_cnt == {{(DWELL_W - 1){1'b0}}, 1'b1}) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers: period counter, duty/resolution outputs and latched command.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pcnt      <= {(DW + 1){1'b0}};
            r_duty      <= {DW{1'b0}};
            r_target    <= {DW{1'b0}};
            r_step      <= {DW{1'b0}};
            r_res       <= {RES_W{1'b0}};
            r_dwell     <= {DWELL_W{1'b0}};
            r_dwell_cnt <= {DWELL_W{1'b0}};
        end else begin
            r_pcnt      <= w_pcnt_nxt;
            r_duty      <= w_duty_nxt;
            r_target    <= w_target_nxt;
            r_step      <= w_step_nxt;
            r_res       <= w_res_nxt;
            r_dwell     <= w_dwell_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: expected outputs come from a closed-form
// timeline model (cycle index -> period index -> duty sequence) built from the ramp rules.
module tb_pwm_ramp_ctrl;
    localparam int DW = 8;
    localparam int RW = 3;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_target;
    logic [DW-1:0] cfg_step;
    logic [RW-1:0] cfg_res;
    logic [WW-1:0] cfg_dwell;
    logic          abort;
    logic [DW-1:0] duty_out;
    logic [RW-1:0] res_out;
    logic          period_tick;
    logic          busy;
    logic          done;
    logic [14:0]   obs;

    int n_tests = 0;
    int n_fail  = 0;
    // Model of idle-time context: edges since the last counter restart, period, duty, resolution.
    int m_k;
    int m_P;
    int m_duty;
    int m_res;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.DW(DW), .RES_W(RW), .DWELL_W(WW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_target(cfg_target), .i_cfg_step(cfg_step),
        .i_cfg_res(cfg_res), .i_cfg_dwell(cfg_dwell), .i_abort(abort),
        .o_duty_out(duty_out), .o_res_out(res_out), .o_period_tick(period_tick),
        .o_busy(busy), .o_done(done)
    );

    assign obs = {duty_out, res_out, period_tick, done, busy, cfg_ready};

    function automatic logic [14:0] pack(int duty, int res, bit tick, bit dn, bit bsy, bit rdy);
        return {duty[7:0], res[2:0], tick, dn, bsy, rdy};
    endfunction

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL %s reset_values: got %h want %h", tag, obs, pack(0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        end
        rst_n  = 1'b1;
        m_k    = 0;
        m_P    = 2;
        m_res  = 0;
        m_duty = 0;
    endtask

    task automatic idle_check(input int ncyc, input string tag);
        logic [14:0] exp;
        for (int i = 0; i < ncyc; i++) begin
            exp = pack(m_duty, m_res, (m_k % m_P) == m_P - 1, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s idle cyc %0d: got %h want %h", tag, i, obs, exp);
            end
            @(negedge clk);
            m_k++;
        end
    endtask

    // frz: -1 none, -2 random cycle, otherwise the cycle index at which ena drops for 7 cycles.
    task automatic ramp_run(input int tgt, input int stp, input int res, input int dw,
                            input bit hold_v, input int frz, input string tag);
        int seq[$];
        int d, s, n, P, D, fa, idx;
        logic [14:0] exp;
        s = (stp == 0) ? 1 : stp;
        d = m_duty;
        seq.push_back(d);
        do begin
            if (((tgt > d) ? tgt - d : d - tgt) <= s) d = tgt;
            else if (tgt > d) d = d + s;
            else d = d - s;
            seq.push_back(d);
        end while (d != tgt);
        n  = seq.size() - 1;
        P  = (1 << res) + 1;
        D  = (n + dw) * P + ((dw == 0) ? 1 : 0);
        fa = (frz == -2) ? int'($urandom_range(0, D)) : frz;

        exp = pack(m_duty, m_res, (m_k % m_P) == m_P - 1, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s pre_accept: got %h want %h", tag, obs, exp);
        end
        cfg_target = tgt[7:0];
        cfg_step   = stp[7:0];
        cfg_res    = res[2:0];
        cfg_dwell  = dw[3:0];
        cfg_valid  = 1'b1;
        @(negedge clk);
        if (hold_v) begin
            cfg_target = 8'($urandom_range(0, 255));
            cfg_step   = 8'($urandom_range(0, 255));
            cfg_res    = 3'($urandom_range(0, 7));
        end else begin
            cfg_valid  = 1'b0;
        end
        for (int k = 0; k <= D + 1; k++) begin
            idx = k / P;
            if (idx > n) idx = n;
            exp = pack(seq[idx], res, (k % P) == P - 1, k == D, k <= D, k > D);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %h want %h", tag, k, obs, exp);
            end
            if (k == fa) begin
                ena = 1'b0;
                for (int j = 0; j < 7; j++) begin
                    @(negedge clk);
                    exp = pack(seq[idx], res, 1'b0, 1'b0, 1'b1, 1'b0);
                    n_tests++;
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL %s frozen cyc %0d+%0d: got %h want %h", tag, k, j, obs, exp);
                    end
                end
                ena = 1'b1;
            end
            if (k == D) cfg_valid = 1'b0;
            if (k <= D) @(negedge clk);
        end
        m_k    = D + 1;
        m_P    = P;
        m_res  = res;
        m_duty = tgt;
    endtask

    task automatic test_reset;
        do_reset("reset");
        idle_check(8, "idle_res0");
        ramp_run(0, 1, 2, 0, 1'b0, -1, "set_res2");
        idle_check(15, "idle_res2");
    endtask

    task automatic test_ramp_up;
        ramp_run(200, 64, 0, 2, 1'b0, -1, "ramp_up");
        idle_check(3, "after_up");
    endtask

    task automatic test_ramp_down;
        ramp_run(10, 100, 1, 0, 1'b0, -1, "ramp_down");
    endtask

    task automatic test_step0_and_equal;
        do_reset("reset_step0");
        ramp_run(3, 0, 0, 1, 1'b0, -1, "step0");
        ramp_run(3, 7, 0, 2, 1'b0, -1, "equal_target");
    endtask

    task automatic test_abort;
        int seq[5];
        int P;
        logic [14:0] exp;
        seq = '{0, 64, 128, 192, 255};
        P = 2;
        do_reset("reset_abort");
        cfg_target = 8'd255;
        cfg_step   = 8'd64;
        cfg_res    = 3'd0;
        cfg_dwell  = 4'd3;
        cfg_valid  = 1'b1;
        @(negedge clk);
        cfg_target = 8'd17;
        cfg_step   = 8'd1;
        for (int k = 0; k <= 3 * P; k++) begin
            if (k < 3 * P) exp = pack(seq[k / P], 0, (k % P) == P - 1, 1'b0, 1'b1, 1'b0);
            else exp = pack(128, 0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got %h want %h", k, obs, exp);
            end
            if (k == 3 * P - 1) begin
                abort     = 1'b1;
                cfg_valid = 1'b0;
            end else begin
                abort     = 1'b0;
            end
            if (k < 3 * P) @(negedge clk);
        end
        m_k    = 3 * P;
        m_duty = 128;
        idle_check(6, "post_abort");
    endtask

    task automatic test_freeze;
        ramp_run(0, 16, 1, 1, 1'b0, 5, "freeze");
    endtask

    task automatic test_reset_hold;
        logic [14:0] exp;
        int d0;
        d0 = m_duty;
        cfg_target = d0[7:0];
        cfg_step   = 8'd5;
        cfg_res    = 3'd1;
        cfg_dwell  = 4'd5;
        cfg_valid  = 1'b1;
        @(negedge clk);
        cfg_valid  = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            exp = pack(d0, 1, (k % 3) == 2, 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL hold_pre_reset cyc %0d: got %h want %h", k, obs, exp);
            end
            if (k < 4) @(negedge clk);
        end
        do_reset("reset_in_hold");
        idle_check(20, "after_hold_reset");
    endtask

    task automatic test_random;
        int tgt, stp, res, dw;
        bit hv, fz;
        for (int t = 0; t < 12; t++) begin
            tgt = $urandom_range(0, 255);
            stp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            res = $urandom_range(0, 2);
            dw  = $urandom_range(0, 15);
            hv  = 1'($urandom_range(0, 1));
            fz  = 1'($urandom_range(0, 1));
            ramp_run(tgt, stp, res, dw, hv, fz ? -2 : -1, $sformatf("rand%0d", t));
            idle_check(int'($urandom_range(0, 4)), $sformatf("rand_idle%0d", t));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_target = 8'd0;
        cfg_step   = 8'd0;
        cfg_res    = 3'd0;
        cfg_dwell  = 4'd0;
        abort      = 1'b0;
        @(negedge clk);
        test_reset;
        test_ramp_up;
        test_ramp_down;
        test_step0_and_equal;
        test_abort;
        test_freeze;
        test_reset_hold;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Sequencer that drives the duty and resolution inputs of the team's 8-bit PWM core. It accepts a ramp command over a valid/ready handshake. It steps the duty value toward a target once per PWM period, dwells at the target for a programmable number of periods, then pulses done. It keeps an internal period counter that mirrors the core's wrap rule, so duty updates land on period boundaries.

Parameters:
DW, 8, duty width (core duty width)
RES_W, 3, resolution select width
DWELL_W, 4, dwell counter width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
ena  input  1  block enable; low freezes all state
cfg_valid  input  1  command valid
cfg_ready  output  1  command accepted when valid&ready
cfg_target  input  DW  final duty value
cfg_step  input  DW  duty increment per period (0 treated as 1)
cfg_res  input  RES_W  resolution select for the core
cfg_dwell  input  DWELL_W  periods to hold at target
abort  input  1  cancel the current ramp
duty_out  output  DW  duty value to the PWM core
res_out  output  RES_W  resolution select to the PWM core
period_tick  output  1  one-cycle pulse on the last cycle of each period
busy  output  1  high in RAMP, HOLD and DONE
done  output  1  one-cycle pulse on ramp+dwell completion

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset, while rst_n=0 at a clk edge:
  - state=IDLE; duty_out=0; res_out=0; pcnt=0; dwell count=0.
  - period_tick=0; busy=0; done=0; cfg_ready=1.
- Reset mid-operation aborts immediately to the reset values; no done pulse.
- ena=0:
  - FSM, pcnt and dwell count hold their values.
  - period_tick=0, done=0, cfg_ready=0.
  - duty_out and res_out hold.
- Period counter pcnt (width DW+1):
  - Counts 0..2^res_out inclusive, then wraps to 0, so period = 2^res_out+1 clocks.
  - period_tick is combinational: (pcnt==2^res_out) & ena.
  - pcnt is reset to 0 on command acceptance.
- FSM states: IDLE, RAMP, HOLD, DONE.
- IDLE:
  - cfg_ready=ena.
  - On cfg_valid&cfg_ready: latch target, step (0 becomes 1) and dwell; load res_out=cfg_res on the same edge; go to RAMP.
  - abort is ignored in IDLE.
- RAMP, on each period_tick:
  - Compute next duty: if |target−duty_out| <= step, next=target; else duty_out±step toward target.
  - Use DW+1-bit arithmetic; no wrap and no overshoot.
  - duty_out <= next.
  - If next==target, go to HOLD and load dwell count=latched dwell. This covers a command whose target equals the current duty: it enters HOLD on the first tick.
- HOLD:
  - If dwell count==0, go to DONE on the next edge.
  - Otherwise decrement on each period_tick; the tick that moves 1→0 also moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. duty_out keeps the target value.
- cfg_ready=0 in RAMP, HOLD and DONE. Commands are never queued; cfg_valid is ignored outside IDLE.
- abort in RAMP or HOLD:
  - Go to IDLE on the next edge; duty_out and res_out hold their current values; no done pulse.
  - abort wins over a coincident period_tick (no duty update that cycle).
- duty_out changes only on a period_tick edge; res_out changes only on command acceptance or reset.
- Latency:
  - Acceptance → first duty update = 2^res+1 cycles.
  - Full ramp = ceil(|target−start|/step) periods.
  - Then dwell periods, plus 1 cycle in DONE.

Test Plan:
1. Reset, then res=2, ena=1, no command → period_tick every 5 clocks; duty_out=0, cfg_ready=1, busy=0.
2. Command target=200, step=64, res=0, dwell=2 from duty 0:
   - Period=2 clocks; duty_out=64,128,192,200 on successive ticks.
   - HOLD for 2 ticks, then done pulses exactly once; duty_out stays 200; cfg_ready returns to 1 the next cycle.
3. Downward ramp from 200 to 10, step=100, res=1 → duty_out=100 then 10, no underflow; dwell=0 → done one cycle after entering HOLD.
4. step=0 with target=3 from 0, res=0 → increments of 1 (1,2,3).
   - Then a command with target equal to the current duty → HOLD on the first tick with duty unchanged.
5. abort asserted in the same cycle as a period_tick mid-ramp (duty=128) → IDLE next edge, duty_out stays 128, no done, cfg_ready=1.
   - Also: cfg_valid held during RAMP is not accepted.
6. Freeze and reset checks:
   - ena=0 for 7 cycles mid-ramp → pcnt, state and duty frozen; ramp resumes with identical tick spacing after ena returns to 1.
   - rst_n=0 for one edge mid-HOLD → all outputs return to reset values; no done.
